// File: rtl/ram_conduit_arbiter.sv
// ============================================================================
// ram_conduit_arbiter: two-requester round-robin arbiter for a 16x16 RAM
// conduit, with read-data routing and bounded atomic lock.   Rev 1.0
// ============================================================================
`default_nettype none

module ram_conduit_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int LOCK_MAX     = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [3:0]  req0_address,
  input  logic [15:0] req0_writedata,
  input  logic [1:0]  req0_byteenable,
  input  logic        req0_lock,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_readdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [3:0]  req1_address,
  input  logic [15:0] req1_writedata,
  input  logic [1:0]  req1_byteenable,
  input  logic        req1_lock,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_readdata,
  output logic [3:0]  ram_address,
  output logic        ram_chipselect,
  output logic        ram_clken,
  output logic        ram_write,
  output logic [15:0] ram_writedata,
  output logic [1:0]  ram_byteenable,
  input  logic [15:0] ram_readdata,
  output logic        lock_timeout
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        clken_q;
  logic        grant0, grant1, accept, gid;
  logic        sel_write, sel_lock;
  logic [3:0]  sel_address;
  logic [15:0] sel_writedata;
  logic [1:0]  sel_byteenable;
  logic        timeout;

  logic        cs_q, cs_d, wr_q, wr_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [READ_LATENCY:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [15:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

  // clken_q doubles as an "out of reset" qualifier so every output is 0 in reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      ST_FREE: begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
      end
      ST_LOCK0: grant0 = req0_valid;
      ST_LOCK1: grant1 = req1_valid;
      default: ;
    endcase
    grant0 = grant0 && clken_q;
    grant1 = grant1 && clken_q;
  end

  assign accept         = grant0 || grant1;
  assign gid            = grant1;
  assign sel_write      = gid ? req1_write      : req0_write;
  assign sel_lock       = gid ? req1_lock       : req0_lock;
  assign sel_address    = gid ? req1_address    : req0_address;
  assign sel_writedata  = gid ? req1_writedata  : req0_writedata;
  assign sel_byteenable = gid ? req1_byteenable : req0_byteenable;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    timeout      = 1'b0;
    if (accept) begin
      last_grant_d = gid;
      lock_cnt_d   = 8'd0;
      if (sel_lock) state_d = gid ? ST_LOCK1 : ST_LOCK0;
      else          state_d = ST_FREE;
    end else if (state_q != ST_FREE) begin
      // an accept in the expiry cycle wins, so only idle cycles can time out
      if (lock_cnt_q == LOCK_LAST) begin
        timeout      = 1'b1;
        state_d      = ST_FREE;
        last_grant_d = (state_q == ST_LOCK1);
        lock_cnt_d   = 8'd0;
      end else begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    cs_d     = accept;
    wr_d     = accept && sel_write;
    be_d     = accept ? sel_byteenable : 2'b00;
    addr_d   = accept ? sel_address    : addr_q;
    wdata_d  = accept ? sel_writedata  : wdata_q;
    tag_v_d  = {tag_v_q[READ_LATENCY-1:0], accept && !sel_write};
    tag_id_d = {tag_id_q[READ_LATENCY-1:0], gid};
    rsp0_valid_d = tag_v_q[READ_LATENCY] && !tag_id_q[READ_LATENCY];
    rsp1_valid_d = tag_v_q[READ_LATENCY] &&  tag_id_q[READ_LATENCY];
    rsp0_data_d  = rsp0_valid_d ? ram_readdata : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? ram_readdata : rsp1_data_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_FREE;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= 8'd0;
      clken_q      <= 1'b0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      be_q         <= 2'b00;
      addr_q       <= 4'd0;
      wdata_q      <= 16'd0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 16'd0;
      rsp1_data_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      clken_q      <= 1'b1;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign req0_ready     = grant0;
  assign req1_ready     = grant1;
  assign lock_timeout   = timeout && clken_q;
  assign ram_clken      = clken_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = wr_q;
  assign ram_byteenable = be_q;
  assign ram_address    = addr_q;
  assign ram_writedata  = wdata_q;
  assign rsp0_valid     = rsp0_valid_q;
  assign rsp1_valid     = rsp1_valid_q;
  assign rsp0_readdata  = rsp0_data_q;
  assign rsp1_readdata  = rsp1_data_q;

endmodule

`default_nettype wire
